// File: rtl/wt_pkg.sv
// Shared constants, phase bit-slice positions and FSM state type for the wavetable reader.
package wt_pkg;
  localparam int PHASE_W = 32;
  localparam int ADDR_W  = 12;
  localparam int DATA_W  = 16;
  localparam int FRAC_W  = 8;
  localparam int MIX_W   = 8;
  localparam int OCT_W   = 8;

  // Address is the top ADDR_W phase bits; the fraction sits directly below it.
  localparam int ADDR_LSB = PHASE_W - ADDR_W;
  localparam int FRAC_LSB = ADDR_LSB - FRAC_W;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    CAPT,
    LERP,
    MIX,
    DONE
  } wt_state_t;
endpackage

// File: rtl/wavetable_reader_lerp16.sv
// Combinational signed linear interpolator: y = a + (((b - a) * w) >>> W), w unsigned.
module lerp16
  import wt_pkg::*;
#(
  parameter int W = FRAC_W
) (
  input  logic signed [DATA_W-1:0] i_a,
  input  logic signed [DATA_W-1:0] i_b,
  input  logic        [W-1:0]      i_w,
  output logic signed [DATA_W-1:0] o_y
);
  localparam int PW = DATA_W + W + 2;

  logic signed [DATA_W:0] w_diff;
  logic signed [W:0]      w_wt;
  logic signed [PW-1:0]   w_diff_x;
  logic signed [PW-1:0]   w_wt_x;
  logic signed [PW-1:0]   w_prod;
  logic signed [PW-1:0]   w_shift;
  logic        [PW-1:0]   w_sum;
  logic                   w_unused;

  assign w_diff   = {i_b[DATA_W-1], i_b} - {i_a[DATA_W-1], i_a};
  assign w_wt     = {1'b0, i_w};
  assign w_diff_x = PW'(w_diff);
  assign w_wt_x   = PW'(w_wt);
  assign w_prod   = w_diff_x * w_wt_x;
  assign w_shift  = w_prod >>> W;
  // The shifted term never exceeds |b - a|, so the sum always fits back in DATA_W.
  assign w_sum    = {{(PW - DATA_W){i_a[DATA_W-1]}}, i_a} + w_shift;
  assign o_y      = w_sum[DATA_W-1:0];
  assign w_unused = ^w_sum[PW-1:DATA_W];
endmodule

// File: rtl/wavetable_reader.sv
// Phase-accumulating wavetable oscillator: one table read per tick, per-bank lerp, bank crossfade.
// Optional feature macro: WT_BANK_XFADE_EN enables bank 1 interpolation and the bankMix crossfade.
module wavetable_reader
  import wt_pkg::*;
(
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_sampleTick,
  input  logic                     i_noteOn,
  input  logic        [PHASE_W-1:0] i_phaseInc,
  input  logic        [OCT_W-1:0]   i_octave,
  input  logic        [MIX_W-1:0]   i_bankMix,
  output logic                     o_readEn,
  output logic        [OCT_W-1:0]   o_octaveOut,
  output logic        [ADDR_W-1:0]  o_sampAddrA,
  input  logic signed [DATA_W-1:0]  i_interpIns [2],
  input  logic signed [DATA_W-1:0]  i_antiInterpIns [2],
  output logic signed [DATA_W-1:0]  o_sampleOut,
  output logic                     o_sampleValid,
  output logic                     o_busy,
  output logic                     o_overrun
);
  wt_state_t r_state;
  wt_state_t w_next;

  logic        [PHASE_W-1:0] r_phase;
  logic        [ADDR_W-1:0]  r_addr;
  logic        [FRAC_W-1:0]  r_frac;
  logic        [OCT_W-1:0]   r_octaveOut;
  logic                      r_note;
  logic                      r_overrun;
  logic signed [DATA_W-1:0]  r_a0;
  logic signed [DATA_W-1:0]  r_b0;
  logic signed [DATA_W-1:0]  r_y0;
  logic signed [DATA_W-1:0]  r_sampleOut;
  logic signed [DATA_W-1:0]  w_y0;
  logic signed [DATA_W-1:0]  w_mix;
  logic                      w_accept;
  logic                      w_readEn;
  logic                      w_valid;
  logic                      w_busy;

  assign w_accept = (r_state == IDLE) && i_sampleTick;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (i_sampleTick) w_next = ADDR;
      ADDR:    w_next = CAPT;
      CAPT:    w_next = LERP;
      LERP:    w_next = MIX;
      MIX:     w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    w_readEn = 1'b0;
    w_valid  = 1'b0;
    w_busy   = 1'b1;
    case (r_state)
      IDLE:    w_busy   = 1'b0;
      ADDR:    w_readEn = 1'b1;
      DONE:    w_valid  = 1'b1;
      default: ;
    endcase
  end

  lerp16 #(.W(FRAC_W)) u_lerp_b0 (
    .i_a (r_a0),
    .i_b (r_b0),
    .i_w (r_frac),
    .o_y (w_y0)
  );

`ifdef WT_BANK_XFADE_EN
  logic        [MIX_W-1:0]  r_mix;
  logic signed [DATA_W-1:0] r_a1;
  logic signed [DATA_W-1:0] r_b1;
  logic signed [DATA_W-1:0] r_y1;
  logic signed [DATA_W-1:0] w_y1;

  lerp16 #(.W(FRAC_W)) u_lerp_b1 (
    .i_a (r_a1),
    .i_b (r_b1),
    .i_w (r_frac),
    .o_y (w_y1)
  );

  lerp16 #(.W(MIX_W)) u_lerp_mix (
    .i_a (r_y0),
    .i_b (r_y1),
    .i_w (r_mix),
    .o_y (w_mix)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_mix <= '0;
      r_a1  <= '0;
      r_b1  <= '0;
      r_y1  <= '0;
    end else begin
      if (w_accept)         r_mix <= i_bankMix;
      if (r_state == CAPT) begin
        r_a1 <= i_interpIns[1];
        r_b1 <= i_antiInterpIns[1];
      end
      if (r_state == LERP)  r_y1 <= w_y1;
    end
  end
`else
  logic w_unused;

  // Without crossfade the MIX stage is a plain register of bank 0.
  assign w_mix    = r_y0;
  assign w_unused = ^{i_bankMix, i_interpIns[1], i_antiInterpIns[1]};
`endif

  // Accept: latch lookup position from the pre-increment phase, then advance.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_phase     <= '0;
      r_addr      <= '0;
      r_frac      <= '0;
      r_octaveOut <= '0;
      r_note      <= 1'b0;
      r_overrun   <= 1'b0;
      r_a0        <= '0;
      r_b0        <= '0;
      r_y0        <= '0;
      r_sampleOut <= '0;
    end else begin
      if (w_accept) begin
        r_addr      <= r_phase[PHASE_W-1:ADDR_LSB];
        r_frac      <= r_phase[ADDR_LSB-1:FRAC_LSB];
        r_octaveOut <= i_octave;
        r_note      <= i_noteOn;
        r_phase     <= i_noteOn ? (r_phase + i_phaseInc) : '0;
      end
      if ((r_state != IDLE) && i_sampleTick) r_overrun <= 1'b1;
      // Capture: table data lands one cycle after the address was presented.
      if (r_state == CAPT) begin
        r_a0 <= i_interpIns[0];
        r_b0 <= i_antiInterpIns[0];
      end
      // Lerp: per-bank interpolation registered.
      if (r_state == LERP) r_y0 <= w_y0;
      // Mix: crossfade result registered straight into the output holding register.
      if (r_state == MIX) r_sampleOut <= r_note ? w_mix : '0;
    end
  end

  assign o_readEn      = w_readEn;
  assign o_sampleValid = w_valid;
  assign o_busy        = w_busy;
  assign o_overrun     = r_overrun;
  assign o_octaveOut   = r_octaveOut;
  assign o_sampAddrA   = r_addr;
  assign o_sampleOut   = r_sampleOut;
endmodule

// File: tb/tb_wavetable_reader.sv
// Self-checking bench for wavetable_reader: vector table plus scoreboard queues and corner sequences.
module tb_wavetable_reader;
  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               tick = 1'b0;
  logic               note = 1'b0;
  logic        [31:0] inc = '0;
  logic        [7:0]  oct = '0;
  logic        [7:0]  mix = '0;
  logic signed [15:0] tb_a [2];
  logic signed [15:0] tb_b [2];
  logic               readEn, valid, busy, overrun;
  logic        [7:0]  octOut;
  logic        [11:0] addr;
  logic signed [15:0] sOut;

  wavetable_reader dut (
    .i_clk           (clk),
    .i_rst           (rst),
    .i_sampleTick    (tick),
    .i_noteOn        (note),
    .i_phaseInc      (inc),
    .i_octave        (oct),
    .i_bankMix       (mix),
    .o_readEn        (readEn),
    .o_octaveOut     (octOut),
    .o_sampAddrA     (addr),
    .i_interpIns     (tb_a),
    .i_antiInterpIns (tb_b),
    .o_sampleOut     (sOut),
    .o_sampleValid   (valid),
    .o_busy          (busy),
    .o_overrun       (overrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] inc;
    logic        note;
    logic [7:0]  mix;
    int          a0, b0, a1, b1;
    logic [11:0] addr;
  } vec_t;

  typedef struct { logic [11:0] addr; logic [7:0] oct; int t; } rd_t;
  typedef struct { int samp; int t; } sv_t;

  rd_t   q_rd[$];
  sv_t   q_sv[$];
  vec_t  vecs[10];
  int    n_tests = 0;
  int    n_fail  = 0;
  int    cyc     = 0;
  int    last_tick = -100;
  bit    mon_en  = 1'b0;
  logic [31:0] m_phase = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic int lerp_m(input int a, input int b, input int w, input int sh);
    real r;
    r = real'((b - a) * w) / real'(1 << sh);
    return a + int'($floor(r));
  endfunction

  function automatic int model(input vec_t v, input logic [31:0] ph);
    int frac, y0, y;
    frac = int'(ph[19:12]);
    y0   = lerp_m(v.a0, v.b0, frac, 8);
`ifdef WT_BANK_XFADE_EN
    y = lerp_m(y0, lerp_m(v.a1, v.b1, frac, 8), int'(v.mix), 8);
`else
    y = y0;
`endif
    return v.note ? y : 0;
  endfunction

  task automatic send(input vec_t v, input logic [7:0] o);
    rd_t r;
    sv_t s;
    @(negedge clk);
    inc = v.inc; note = v.note; mix = v.mix; oct = o;
    tb_a[0] = 16'(v.a0); tb_b[0] = 16'(v.b0);
    tb_a[1] = 16'(v.a1); tb_b[1] = 16'(v.b1);
    tick = 1'b1;
    r.addr = v.addr; r.oct = o; r.t = cyc;
    s.samp = model(v, m_phase); s.t = cyc;
    q_rd.push_back(r);
    q_sv.push_back(s);
    last_tick = cyc;
    m_phase = v.note ? m_phase + v.inc : 32'h0;
    @(negedge clk);
    tick = 1'b0;
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (readEn) begin
        if (q_rd.size() == 0) chk("unexpected_readEn", 1, 0);
        else begin
          rd_t r;
          r = q_rd.pop_front();
          chk("readEn_cycle", cyc, r.t + 1);
          chk("sampAddrA", int'(addr), int'(r.addr));
          chk("octaveOut", int'(octOut), int'(r.oct));
        end
      end
      if (valid) begin
        if (q_sv.size() == 0) chk("unexpected_sampleValid", 1, 0);
        else begin
          sv_t s;
          s = q_sv.pop_front();
          chk("valid_cycle", cyc, s.t + 5);
          chk("sampleOut", int'(sOut), s.samp);
        end
      end
      chk("busy", int'(busy),
          int'((cyc >= last_tick + 1) && (cyc <= last_tick + 5)));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    int   t0;
    bit   bad;
    tb_a[0] = '0; tb_a[1] = '0; tb_b[0] = '0; tb_b[1] = '0;
    //          inc           note mix    a0      b0     a1     b1    addr
    vecs[0] = '{32'h0008_0000, 1'b1, 8'h00,    100,   200,     0,     0, 12'h000};
    vecs[1] = '{32'hFFFC_0000, 1'b1, 8'h00,   1000,  2000,     0,     0, 12'h000};
    vecs[2] = '{32'h000C_0000, 1'b1, 8'h00,  -1000,  1000,     0,     0, 12'h000};
    vecs[3] = '{32'h0010_0000, 1'b1, 8'h40,      7,     7,   300,   300, 12'h001};
    vecs[4] = '{32'h0010_0000, 1'b1, 8'h00,   -300,   500,     0,     0, 12'h002};
    vecs[5] = '{32'hFFC8_0000, 1'b1, 8'h00,  32767,-32768,     0,     0, 12'h003};
    vecs[6] = '{32'h0010_0000, 1'b1, 8'h00, -32768, 32767,     0,     0, 12'hFFF};
    vecs[7] = '{32'h0000_0000, 1'b1, 8'h80,   1000,  1000, -1000, -1000, 12'h000};
    vecs[8] = '{32'h0010_0000, 1'b0, 8'h00,    123,   456,     0,     0, 12'h000};
    vecs[9] = '{32'h0010_0000, 1'b1, 8'hFF,     55,    55,  -201,  -201, 12'h000};

    // Reset values, with reset held and after release.
    repeat (3) @(negedge clk);
    chk("rst_readEn", int'(readEn), 0);
    chk("rst_valid", int'(valid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_overrun", int'(overrun), 0);
    chk("rst_sampleOut", int'(sOut), 0);
    chk("rst_addr", int'(addr), 0);
    chk("rst_octaveOut", int'(octOut), 0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_busy", int'(busy), 0);
    mon_en = 1'b1;

    // Hand-computed spot checks of the key spec examples.
    chk("model_1500", model(vecs[1], 32'h0008_0000), 1500);
    chk("model_m500", model(vecs[2], 32'h0004_0000), -500);

    for (int i = 0; i < 10; i++) begin
      send(vecs[i], 8'(1 << (i % 8)));
      repeat (6) @(negedge clk);
    end
    chk("no_overrun_table", int'(overrun), 0);

    // Tick during a computation is dropped and flags overrun.
    v = '{32'h0010_0000, 1'b1, 8'h00, 42, 42, 0, 0, 12'h001};
    send(v, 8'h10);
    @(negedge clk);
    @(negedge clk);
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    repeat (6) @(negedge clk);
    chk("overrun_set", int'(overrun), 1);
    v = '{32'h0010_0000, 1'b1, 8'h00, -9, 11, 0, 0, 12'h002};
    send(v, 8'h20);
    repeat (6) @(negedge clk);
    chk("overrun_sticky", int'(overrun), 1);

    // Reset in cycle T+3 of a computation: it is abandoned with no sampleValid.
    mon_en = 1'b0;
    @(negedge clk);
    t0 = cyc;
    note = 1'b1; inc = 32'h0010_0000; tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    while (cyc < t0 + 3) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_overrun", int'(overrun), 0);
    chk("midrst_sampleOut", int'(sOut), 0);
    chk("midrst_addr", int'(addr), 0);
    chk("midrst_octaveOut", int'(octOut), 0);
    bad = 1'b0;
    repeat (2) begin
      @(negedge clk);
      if (valid || readEn || busy) bad = 1'b1;
    end
    rst = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (valid || readEn || busy) bad = 1'b1;
    end
    chk("midrst_no_activity", int'(bad), 0);
    m_phase = '0;
    last_tick = -100;
    mon_en = 1'b1;
    v = '{32'h0010_0000, 1'b1, 8'h00, 250, 350, 0, 0, 12'h000};
    send(v, 8'h01);
    repeat (6) @(negedge clk);
    v = '{32'h0010_0000, 1'b1, 8'h00, 0, 0, 0, 0, 12'h001};
    send(v, 8'h02);

    for (int k = 0; k < 20 && (q_rd.size() != 0 || q_sv.size() != 0); k++)
      @(negedge clk);
    chk("scoreboard_drained", q_rd.size() + q_sv.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/wavetable_reader.md
# wavetable_reader

Phase-accumulating wavetable oscillator that drives the 8-octave sawtooth table block as its read initiator. On each audio-rate sampleTick it advances a 32-bit phase, issues one table read (address plus one-hot octave), and takes back both neighbouring samples for the selected bank and the next-lower bank. It then linearly interpolates within each bank, crossfades between the two banks, and presents one signed 16-bit sample with a valid pulse to the voice mixer.

## Interface
- PHASE_W, 32, phase accumulator width
- ADDR_W, 12, table address width (4096 entries)
- DATA_W, 16, signed sample width
- FRAC_W, 8, interpolation fraction bits, taken directly below the address bits
- Clk  in  1  system clock; all state changes on its rising edge
- Reset  in  1  asynchronous, active-high reset
- sampleTick  in  1  one-cycle strobe at the audio sample rate
- noteOn  in  1  voice gate
- phaseInc  in  PHASE_W  tuning word, unsigned
- octave  in  8  one-hot octave select
- bankMix  in  8  crossfade weight toward bank 1 (0 = all bank 0)
- readEn  out  1  table read enable
- octaveOut  out  8  octave presented to the table
- sampAddrA  out  ADDR_W  table address; the table reads A and A+1
- interpIns[2]  in  DATA_W  table samples at A, for bank 0 and bank 1
- antiInterpIns[2]  in  DATA_W  table samples at A+1, for bank 0 and bank 1
- sampleOut  out  DATA_W  signed output sample, held between updates
- sampleValid  out  1  one-cycle pulse when sampleOut updates
- busy  out  1  high from the cycle after an accepted tick until sampleValid
- overrun  out  1  sticky flag; cleared only by Reset

## Operation
- FSM states: IDLE, ADDR, CAPT, LERP, MIX, DONE.
- IDLE: when sampleTick=1, accept the tick.
  - Latch phase, octave and bankMix.
  - Update the accumulator: phase <= phase + phaseInc (mod 2^PHASE_W), or phase <= 0 if noteOn=0.
  - Go to ADDR.
- ADDR:
  - readEn=1.
  - sampAddrA = latched phase[31:20].
  - octaveOut = latched octave.
  - Go to CAPT.
- CAPT: register interpIns and antiInterpIns (the table has a registered address, so data arrives one cycle after ADDR). Go to LERP.
- LERP: per bank, y = a + (((b − a) × frac) >>> FRAC_W).
  - frac = latched phase[19:12], unsigned.
  - b − a is computed at 17 bits signed; the product at 26 bits signed; the shift is arithmetic.
  - The result lies between a and b and is truncated to 16 bits without overflow.
  - Register y0 and y1. Go to MIX.
- MIX: out = y0 + (((y1 − y0) × bankMix) >>> 8), same width rules. Register the result. Go to DONE.
- DONE:
  - sampleValid=1.
  - sampleOut = the MIX result, or 0 if the latched noteOn=0.
  - Go to IDLE.
- The lookup uses the phase value from before the increment.
- Phase wrap from 0xFFFF_FFFF to 0 is natural modulo wrap. At address 0xFFF the table's A+1 read wraps to 0, so interpolation stays continuous across the wrap.
- A sampleTick outside IDLE is ignored and sets overrun.
- phaseInc, octave and bankMix changes take effect only at the next accepted tick. octaveOut and sampAddrA hold stable from ADDR until the next ADDR.
- Reset at any time: the FSM goes to IDLE and all registers clear, including an in-flight computation; no sampleValid is produced for it.

## Timing
- Reset values: readEn=0, octaveOut=0, sampAddrA=0, sampleOut=0, sampleValid=0, busy=0, overrun=0, phase=0.
- Latency: with sampleTick high in cycle T (FSM in IDLE):
  - readEn=1 in cycle T+1 only.
  - sampleValid=1 in cycle T+5 only.
- busy is high in cycles T+1 through T+5.
- Minimum tick spacing is 6 cycles. A tick in cycle T+6 is accepted.
- readEn is asserted for exactly one cycle per accepted tick.

## Configuration
- WT_BANK_XFADE_EN defined:
  - MIX performs the bank 0/bank 1 crossfade with bankMix.
  - Bank 1 LERP is instantiated.
- WT_BANK_XFADE_EN undefined:
  - bankMix is ignored.
  - The MIX result equals y0, and the bank 1 LERP is removed.
  - The MIX stage stays as a pure register stage, so latency is unchanged (sampleValid at T+5).

## Structure
- Package wt_pkg:
  - wt_state_t enum (IDLE, ADDR, CAPT, LERP, MIX, DONE).
  - Constants PHASE_W, ADDR_W, DATA_W, FRAC_W, MIX_W=8.
  - Address and fraction bit-slice positions.
- Sub-module lerp16: combinational signed a + ((b − a) × w >>> W), with W as a parameter. It is instanced for bank 0 LERP, bank 1 LERP and MIX.

## Test plan
- Reset asserted mid-computation (cycle T+3) → no sampleValid; all outputs 0; busy=0; after release, a tick yields readEn at T'+1.
- phaseInc=0x0010_0000, noteOn=1, three ticks 8 cycles apart → sampAddrA=0x000, 0x001, 0x002; sampleValid at T+5 each time; overrun=0.
- phase=0x0008_0000 (frac=0x80), bank 0 a=1000, b=2000, bankMix=0 → sampleOut=1500. Then a=−1000, b=1000, frac=0x40 → sampleOut=−500.
- phase=0xFFF8_0000, phaseInc=0x0010_0000 → sampAddrA=0xFFF, frac=0x80; next tick looks up phase 0x0008_0000 → sampAddrA=0x000.
- y0=1000, y1=−1000, bankMix=0x80 → sampleOut=0 with WT_BANK_XFADE_EN, 1000 without.
- Second tick at T+3 → ignored, overrun=1, one sampleValid only. noteOn=0 tick → sampleOut=0 with a sampleValid pulse, and phase=0 afterward.
